// File: rtl/fft_uart_sched_pkg.sv
// fft_uart_sched_pkg: shared types and constants for the UART<->FFT frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scheduler state enumeration, byte-lane positions of re/im in the
// 16-bit sample words, and calc_aw() which derives the address width from N.
package fft_uart_sched_pkg;

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_START   = 3'd1,
    S_RUN     = 3'd2,
    S_FETCH   = 3'd3,
    S_SEND_RE = 3'd4,
    S_SEND_IM = 3'd5
  } state_t;

  // Sample word layout: {re[7:0], im[7:0]}
  localparam int RE_HI = 15;
  localparam int RE_LO = 8;
  localparam int IM_HI = 7;
  localparam int IM_LO = 0;

  // Smallest aw with 2**aw >= n (n is a power of two, so this is log2(n)).
  function automatic int calc_aw(input int n);
    int aw;
    aw = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) aw = i + 1;
    end
    return aw;
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// fft_bitrev_addr: reverses the bit order of an AW-bit sample index.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of i_addr).
// Ports: i_addr  natural sample index
//        o_addr  bit-reversed index for a decimation-in-time input buffer
// Only compiled when FFT_BITREV_EN is defined; the default build has no use for it.
`ifdef FFT_BITREV_EN
module fft_bitrev_addr #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] i_addr,
  output logic [AW-1:0] o_addr
);

  for (genvar g = 0; g < AW; g++) begin : g_rev
    assign o_addr[g] = i_addr[AW-1-g];
  end

endmodule
`endif

// File: rtl/fft_uart_sched.sv
// fft_uart_sched: sequences UART RX bytes -> FFT input buffer -> FFT -> result buffer -> UART TX.
// Latency: last im byte -> buf_we +1 clk, fft_start +2 clk; fft_done -> first tx byte +3 clk.
// Backpressure: tx_valid held with stable tx_data until tx_ready; RX has none, bytes outside LOAD are dropped (overrun).
// Ports: clk/rst_n (sync, active-low); rx_valid/rx_data byte strobe in;
//        buf_we/buf_waddr/buf_wdata input-buffer write; fft_start/fft_done core handshake;
//        res_raddr/res_rdata result-buffer read (1-clk read latency);
//        tx_valid/tx_data/tx_ready byte stream out; busy (not LOAD); overrun (sticky).
// Build option: FFT_BITREV_EN -> buf_waddr is the bit-reversed sample index.
module fft_uart_sched
  import fft_uart_sched_pkg::*;
#(
  parameter  int N       = 256,
  parameter  int TIMEOUT = 5000,
  localparam int AW      = calc_aw(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [15:0]   buf_wdata,
  output logic          fft_start,
  input  logic          fft_done,
  output logic [AW-1:0] res_raddr,
  input  logic [15:0]   res_rdata,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          busy,
  output logic          overrun
);

  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   BC_LAST   = (AW+1)'(2*N - 1);
  localparam logic [AW-1:0] K_LAST    = AW'(N - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_bcnt;
  logic [TW-1:0] r_idle;
  logic [7:0]    r_re_in;
  logic          r_frame_done;
  logic [AW-1:0] r_k;
  logic          r_fph;
  logic [7:0]    r_tx_re;
  logic [7:0]    r_tx_im;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [15:0]   r_wdata;
  logic          r_overrun;

  logic          w_expire;
  logic [AW:0]   w_bcnt_eff;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_waddr;

  // The idle counter reaches TIMEOUT on this clock unless a byte arrives.
  // A byte arriving on that same clock starts a fresh frame as byte 0.
  assign w_expire   = (r_bcnt != '0) && (r_idle == IDLE_LAST);
  assign w_bcnt_eff = w_expire ? '0 : r_bcnt;
  assign w_idx      = w_bcnt_eff[AW:1];

`ifdef FFT_BITREV_EN
  fft_bitrev_addr #(.AW(AW)) u_bitrev (
    .i_addr (w_idx),
    .o_addr (w_waddr)
  );
`else
  assign w_waddr = w_idx;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    fft_start   = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    busy        = 1'b1;
    case (r_state)
      S_LOAD: begin
        busy = 1'b0;
        // Wait one clock after the last write so fft_start follows buf_we.
        if (r_frame_done) w_state_nxt = S_START;
      end
      S_START: begin
        fft_start   = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (fft_done) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // Phase 0 presents the address, phase 1 captures the read data.
        if (r_fph) w_state_nxt = S_SEND_RE;
      end
      S_SEND_RE: begin
        tx_valid = 1'b1;
        tx_data  = r_tx_re;
        if (tx_ready) w_state_nxt = S_SEND_IM;
      end
      S_SEND_IM: begin
        tx_valid = 1'b1;
        tx_data  = r_tx_im;
        if (tx_ready) w_state_nxt = (r_k == K_LAST) ? S_LOAD : S_FETCH;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Datapath: byte assembly, timeout, result fetch, overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcnt       <= '0;
      r_idle       <= '0;
      r_re_in      <= '0;
      r_frame_done <= 1'b0;
      r_k          <= '0;
      r_fph        <= 1'b0;
      r_tx_re      <= '0;
      r_tx_im      <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (rx_valid && (r_state != S_LOAD)) r_overrun <= 1'b1;

      case (r_state)
        S_LOAD: begin
          r_frame_done <= 1'b0;
          if (rx_valid) begin
            r_idle <= '0;
            if (!w_bcnt_eff[0]) begin
              r_re_in <= rx_data;
              r_bcnt  <= w_bcnt_eff + 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_waddr <= w_waddr;
              r_wdata <= {r_re_in, rx_data};
              if (w_bcnt_eff == BC_LAST) begin
                r_bcnt       <= '0;
                r_frame_done <= 1'b1;
              end else begin
                r_bcnt <= w_bcnt_eff + 1'b1;
              end
            end
          end else if (r_bcnt != '0) begin
            // Partial frame: drop it once the link has been quiet too long.
            if (w_expire) begin
              r_bcnt <= '0;
              r_idle <= '0;
            end else begin
              r_idle <= r_idle + 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (r_fph) begin
            r_tx_re <= res_rdata[RE_HI:RE_LO];
            r_tx_im <= res_rdata[IM_HI:IM_LO];
            r_fph   <= 1'b0;
          end else begin
            r_fph <= 1'b1;
          end
        end
        S_SEND_IM: begin
          if (tx_ready) begin
            if (r_k == K_LAST) begin
              r_k    <= '0;
              r_bcnt <= '0;
              r_idle <= '0;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign buf_we    = r_we;
  assign buf_waddr = r_waddr;
  assign buf_wdata = r_wdata;
  assign res_raddr = r_k;
  assign overrun   = r_overrun;

endmodule
